// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the ram_sync storage primitive.
//   ram_state_t : CLEAR (zeroing the array after reset) / IDLE (serving requests)
//   parity_f    : even-parity bit of a vector, only used when RAM_PARITY_EN is defined
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } ram_state_t;

  // Widest data word parity_f accepts; narrower words are zero-extended,
  // which does not change their parity.
  localparam int PARITY_MAX_W = 1024;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic parity_f(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ram_init_ctrl.sv
// ram_init_ctrl: post-reset clear sequencer for ram_sync.
//   clk, rst_n : clock, asynchronous active-low reset
//   done       : 1 once every word has been cleared (state is IDLE)
//   clr_we     : write-enable for the clear write of this cycle
//   clr_addr   : word address being cleared this cycle
//   state      : current FSM state, exposed for debug and checkers
// Counts 0..DEPTH-1 in CLEAR, one word per cycle, then parks in IDLE until
// the next reset. The clear therefore takes exactly DEPTH cycles.
module ram_init_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output ram_state_t    state
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  ram_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we   = 1'b0;
    clr_addr = cnt_q;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == LAST) state_d = IDLE;
        else               cnt_d   = cnt_q + AW'(1);
      end
      IDLE:    ;
      default: state_d = CLEAR;
    endcase
  end

  assign done  = (state_q == IDLE);
  assign state = state_q;

endmodule

// File: rtl/ram_sync.sv
// ram_sync: parametrised single-port synchronous RAM with registered reads.
//   clk, rst_n : clock, asynchronous active-low reset
//   en, we     : request strobe; we=1 write, we=0 read
//   addr, wdata: word address and write data
//   ready      : high once the post-reset clear of every word has finished
//   rdata      : registered read data, held until the next accepted read
//   rvalid     : one-cycle pulse, rdata was updated by a read
//   perr       : (RAM_PARITY_EN only) parity mismatch on the read, aligned with rvalid
//   err        : one-cycle pulse, accepted request addressed a word >= DEPTH
// Handshake: a request is accepted on a rising edge where en && ready; there is
// no other back-pressure, and en while ready=0 has no effect at all.
// Build option: define RAM_PARITY_EN to store an even-parity bit per word.
module ram_sync
  import ram_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
`ifdef RAM_PARITY_EN
  output logic          perr,
`endif
  output logic          err
);

`ifdef RAM_PARITY_EN
  localparam int MW = DW + 1;   // {parity, data}
`else
  localparam int MW = DW;
`endif

  // One extra bit so DEPTH itself is representable when it is a power of two.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [MW-1:0] mem [DEPTH];

  logic          done, clr_we;
  logic [AW-1:0] clr_addr;
  ram_state_t    init_state;

  ram_init_ctrl #(.DEPTH(DEPTH), .AW(AW)) u_init (
    .clk      (clk),
    .rst_n    (rst_n),
    .done     (done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .state    (init_state)
  );

  logic          accept, in_range;
  logic [MW-1:0] wr_word, rd_word;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [MW-1:0] mem_wdata;

  assign ready    = done;
  assign accept   = en && ready;
  assign in_range = ({1'b0, addr} < DEPTH_W);

`ifdef RAM_PARITY_EN
  assign wr_word = {parity_f(PARITY_MAX_W'(wdata)), wdata};
`else
  assign wr_word = wdata;
`endif

  // Out-of-range reads return zero rather than touching the array.
  assign rd_word = in_range ? mem[addr] : '0;

  // Clear writes own the array port while clearing; user writes only after.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = '0;
    if (init_state == CLEAR) begin
      mem_we    = clr_we;
      mem_waddr = clr_addr;
    end else if (accept && we && in_range) begin
      mem_we    = 1'b1;
      mem_wdata = wr_word;
    end
  end

  // Array contents are not reset; the clear sequence zeroes them instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;
`ifdef RAM_PARITY_EN
  logic          perr_q, perr_d;
`endif

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
`ifdef RAM_PARITY_EN
    perr_d   = 1'b0;
`endif
    if (accept) begin
      err_d = !in_range;
      if (!we) begin
        rvalid_d = 1'b1;
        rdata_d  = rd_word[DW-1:0];
`ifdef RAM_PARITY_EN
        // A good word has an even number of ones across data and parity.
        perr_d   = ^rd_word;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef RAM_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
`ifdef RAM_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;
`ifdef RAM_PARITY_EN
  assign perr   = perr_q;
`endif

endmodule
